// File: rtl/sd_image_read_ctrl.sv
// Multi-sector SD image read sequencer. Issues one sector read at a time once the
// downstream FIFO can take a whole sector, forwards read data into the FIFO, and
// reports per-image completion plus sticky error flags.
module sd_image_read_ctrl #(
  parameter logic [31:0] START_SEC  = 32'd20000,
  parameter int unsigned SEC_NUM    = 1200,
  parameter int unsigned SEC_WORDS  = 256,
  parameter int unsigned FIFO_DEPTH = 2048,
  parameter int unsigned LEN_W      = 11,
  parameter int unsigned BUSY_TO    = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sd_init_done,
  input  logic             image_read_req,
  input  logic             rd_busy,
  input  logic             rd_val_en,
  input  logic [15:0]      rd_val_data,
  output logic             rd_start_en,
  output logic [31:0]      rd_sec_addr,
  output logic             fifo_wr_en,
  output logic [15:0]      fifo_wr_data,
  input  logic             fifo_full,
  input  logic [LEN_W-1:0] fifo_wr_len,
  output logic             busy,
  output logic             image_done,
  output logic [15:0]      sec_cnt,
  output logic [2:0]       err_flag
);

  localparam int unsigned     TO_W      = (BUSY_TO > 2) ? $clog2(BUSY_TO) : 1;
  // Highest fill level that still leaves room for one full sector.
  localparam logic [LEN_W:0]  ROOM_LIM  = (LEN_W + 1)'(FIFO_DEPTH - SEC_WORDS);
  localparam logic [8:0]      WORDS_EXP = 9'(SEC_WORDS);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(BUSY_TO - 1);
  localparam logic [15:0]     SEC_LAST  = 16'(SEC_NUM);

  typedef enum logic [2:0] {
    StIdle,
    StWaitRoom,
    StStart,
    StWaitBusy,
    StXfer,
    StNext
  } state_e;

  state_e          state_q, state_d;
  logic            req_q;
  logic [8:0]      word_cnt_q;
  logic [TO_W-1:0] to_cnt_q;

  logic       req_accept;
  logic       room_ok;
  logic       to_hit;
  logic [8:0] word_cnt_inc;
  logic [8:0] word_cnt_nxt;

  // Request edges only count in IDLE with a ready card; anything else is dropped.
  assign req_accept   = (state_q == StIdle) & sd_init_done & image_read_req & ~req_q;
  assign room_ok      = ({1'b0, fifo_wr_len} <= ROOM_LIM);
  assign to_hit       = (to_cnt_q == TO_LAST);
  assign word_cnt_inc = (word_cnt_q == 9'd511) ? word_cnt_q : word_cnt_q + 9'd1;
  // Includes a word arriving in the same cycle rd_busy falls.
  assign word_cnt_nxt = rd_val_en ? word_cnt_inc : word_cnt_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and single-cycle strobes.
  always_comb begin
    state_d     = state_q;
    rd_start_en = 1'b0;
    image_done  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_accept) state_d = StWaitRoom;
      end
      StWaitRoom: begin
        if (room_ok) state_d = StStart;
      end
      StStart: begin
        rd_start_en = 1'b1;
        state_d     = StWaitBusy;
      end
      StWaitBusy: begin
        if (rd_busy) begin
          state_d = StXfer;
        end else if (to_hit) begin
          state_d = StStart;
        end
      end
      StXfer: begin
        if (!rd_busy) state_d = StNext;
      end
      StNext: begin
        if (sec_cnt == SEC_LAST) begin
          image_done = 1'b1;
          state_d    = StIdle;
        end else begin
          state_d = StWaitRoom;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath: counters, address, FIFO write port, status and error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q        <= 1'b0;
      word_cnt_q   <= '0;
      to_cnt_q     <= '0;
      rd_sec_addr  <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      busy         <= 1'b0;
      sec_cnt      <= '0;
      err_flag     <= '0;
    end else begin
      req_q      <= image_read_req;
      fifo_wr_en <= (state_q == StXfer) & rd_val_en & ~fifo_full;
      if ((state_q == StXfer) && rd_val_en) fifo_wr_data <= rd_val_data;

      if (req_accept) begin
        sec_cnt  <= '0;
        err_flag <= '0;
        busy     <= 1'b1;
      end

      // Address is loaded on entry so it is already valid in the start cycle.
      if (state_d == StStart) rd_sec_addr <= START_SEC + {16'd0, sec_cnt};

      case (state_q)
        StStart: begin
          word_cnt_q <= '0;
          to_cnt_q   <= '0;
        end
        StWaitBusy: begin
          if (!rd_busy) begin
            if (to_hit) begin
              err_flag[1] <= 1'b1;
            end else begin
              to_cnt_q <= to_cnt_q + 1'b1;
            end
          end
        end
        StXfer: begin
          word_cnt_q <= word_cnt_nxt;
          if (rd_val_en && fifo_full) err_flag[2] <= 1'b1;
          if (!rd_busy) begin
            if (word_cnt_nxt != WORDS_EXP) err_flag[0] <= 1'b1;
            sec_cnt <= sec_cnt + 16'd1;
          end
        end
        StNext: begin
          if (sec_cnt == SEC_LAST) busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_image_read_ctrl.sv
// Self-checking bench for sd_image_read_ctrl: a randomized SD-controller model
// drives sectors, a scoreboard collects start addresses and FIFO writes, and a
// scenario table gives the expected error flags for each image.
module tb_sd_image_read_ctrl;

  localparam int unsigned SEC_NUM   = 3;
  localparam int unsigned SEC_WORDS = 256;
  localparam int unsigned START     = 20000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sd_init_done = 1'b1;
  logic        image_read_req = 1'b0;
  logic        rd_busy = 1'b0;
  logic        rd_val_en = 1'b0;
  logic [15:0] rd_val_data = '0;
  logic        rd_start_en;
  logic [31:0] rd_sec_addr;
  logic        fifo_wr_en;
  logic [15:0] fifo_wr_data;
  logic        fifo_full = 1'b0;
  logic [10:0] fifo_wr_len = '0;
  logic        busy;
  logic        image_done;
  logic [15:0] sec_cnt;
  logic [2:0]  err_flag;

  sd_image_read_ctrl #(
    .SEC_NUM(SEC_NUM)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sd_init_done  (sd_init_done),
    .image_read_req(image_read_req),
    .rd_busy       (rd_busy),
    .rd_val_en     (rd_val_en),
    .rd_val_data   (rd_val_data),
    .rd_start_en   (rd_start_en),
    .rd_sec_addr   (rd_sec_addr),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_wr_data  (fifo_wr_data),
    .fifo_full     (fifo_full),
    .fifo_wr_len   (fifo_wr_len),
    .busy          (busy),
    .image_done    (image_done),
    .sec_cnt       (sec_cnt),
    .err_flag      (err_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         short_sec;   // sector returning 255 words, -1 none
    int         long_sec;    // sector returning 257 words, -1 none
    int         ignore_sec;  // sector whose first start is ignored, -1 none
    int         full_sec;    // sector with fifo_full over its first 10 words, -1 none
    bit         tail_fall;   // last word arrives in the cycle rd_busy falls
    logic [2:0] exp_err;
  } scen_t;

  scen_t scen [6];

  int total = 0;
  int bad   = 0;
  bit abort = 1'b0;

  logic [31:0] exp_addr[$];
  logic [31:0] got_addr[$];
  logic [15:0] exp_data[$];
  logic [15:0] got_data[$];
  int          done_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    exp_addr.delete();
    got_addr.delete();
    exp_data.delete();
    got_data.delete();
    done_cnt = 0;
  endtask

  // Scoreboard capture, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_start_en) got_addr.push_back(rd_sec_addr);
      if (fifo_wr_en) got_data.push_back(fifo_wr_data);
      if (image_done) done_cnt++;
    end
  end

  task automatic wait_start(input int limit, output bit ok, output int waited);
    ok = 1'b0;
    waited = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (rd_start_en) begin
        ok = 1'b1;
        waited = i + 1;
        break;
      end
    end
  endtask

  // SD controller model: raise busy after a random delay, stream nwords words with
  // random gaps, then drop busy. Words presented while full are not expected in the FIFO.
  task automatic serve_sector(input int nwords, input int full_words, input bit tail_fall);
    repeat ($urandom_range(1, 3)) step();
    rd_busy = 1'b1;
    for (int w = 0; w < nwords; w++) begin
      step();
      if ($urandom_range(0, 3) == 0) begin
        rd_val_en = 1'b0;
        step();
      end
      rd_val_en   = 1'b1;
      rd_val_data = 16'($urandom);
      fifo_full   = (w < full_words);
      if (!fifo_full) exp_data.push_back(rd_val_data);
      if (tail_fall && (w == nwords - 1)) rd_busy = 1'b0;
    end
    step();
    rd_val_en = 1'b0;
    fifo_full = 1'b0;
    rd_busy   = 1'b0;
  endtask

  task automatic run_image(input scen_t sc);
    bit ok;
    int waited;
    int nwords;
    int mism;
    clear_sb();
    fifo_wr_len = 11'($urandom_range(0, 1792));
    step();
    image_read_req = 1'b1;
    step();
    check({sc.name, "_busy_set"}, 32'(busy), 32'd1);
    for (int s = 0; s < int'(SEC_NUM); s++) begin
      nwords = (s == sc.short_sec) ? 255 : (s == sc.long_sec) ? 257 : 256;
      wait_start(3000, ok, waited);
      check({sc.name, "_start_seen"}, 32'(ok), 32'd1);
      if (!ok) begin
        abort = 1'b1;
        return;
      end
      exp_addr.push_back(32'(START + s));
      if (s == sc.ignore_sec) begin
        wait_start(200, ok, waited);
        check({sc.name, "_retry_seen"}, 32'(ok), 32'd1);
        if (!ok) begin
          abort = 1'b1;
          return;
        end
        check({sc.name, "_timeout_gap"}, 32'(waited), 32'd65);
        check({sc.name, "_err1_at_retry"}, 32'(err_flag[1]), 32'd1);
        exp_addr.push_back(32'(START + s));
      end
      // Card-ready falling mid-image must not disturb the read.
      if (s == 0) sd_init_done = 1'b0;
      serve_sector(nwords, (s == sc.full_sec) ? 10 : 0, sc.tail_fall);
      fifo_wr_len = 11'($urandom_range(0, 1792));
      if (s == 0) begin
        // A fresh request edge while busy is ignored.
        image_read_req = 1'b0;
        step();
        image_read_req = 1'b1;
      end
    end
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (image_done) begin
        ok = 1'b1;
        break;
      end
    end
    check({sc.name, "_done_seen"}, 32'(ok), 32'd1);
    check({sc.name, "_err_flag"}, 32'(err_flag), 32'(sc.exp_err));
    check({sc.name, "_sec_cnt"}, 32'(sec_cnt), 32'(SEC_NUM));
    @(negedge clk);
    check({sc.name, "_busy_clear"}, 32'(busy), 32'd0);
    check({sc.name, "_done_count"}, 32'(done_cnt), 32'd1);
    check({sc.name, "_start_count"}, 32'(got_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      check({sc.name, "_addr"}, got_addr[i], exp_addr[i]);
    end
    check({sc.name, "_write_count"}, 32'(got_data.size()), 32'(exp_data.size()));
    mism = 0;
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      if (got_data[i] !== exp_data[i]) mism++;
    end
    check({sc.name, "_data_mismatches"}, 32'(mism), 32'd0);
    image_read_req = 1'b0;
    sd_init_done   = 1'b1;
    step();
    step();
  endtask

  initial begin
    bit ok;
    int waited;

    scen[0] = '{"nominal",  -1, -1, -1, -1, 1'b0, 3'b000};
    scen[1] = '{"timeout",  -1, -1,  0, -1, 1'b0, 3'b010};
    scen[2] = '{"short",     1, -1, -1, -1, 1'b0, 3'b001};
    scen[3] = '{"overflow", -1, -1, -1,  2, 1'b0, 3'b100};
    scen[4] = '{"long",     -1,  0, -1, -1, 1'b0, 3'b001};
    scen[5] = '{"tailfall", -1, -1, -1, -1, 1'b1, 3'b000};

    // Reset state.
    repeat (3) step();
    check("rst_start", 32'(rd_start_en), 32'd0);
    check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(image_done), 32'd0);
    check("rst_sec_cnt", 32'(sec_cnt), 32'd0);
    check("rst_err", 32'(err_flag), 32'd0);
    check("rst_addr", rd_sec_addr, 32'd0);
    rst = 1'b0;
    step();

    // Request while the card is not ready is dropped, not queued.
    clear_sb();
    sd_init_done = 1'b0;
    image_read_req = 1'b1;
    repeat (20) step();
    check("gate_busy", 32'(busy), 32'd0);
    sd_init_done = 1'b1;
    repeat (10) step();
    check("gate_no_start", 32'(got_addr.size()), 32'd0);
    check("gate_busy_after_ready", 32'(busy), 32'd0);
    image_read_req = 1'b0;
    step();

    // Backpressure: no start while the FIFO lacks room for a sector.
    clear_sb();
    fifo_wr_len = 11'd1793;
    image_read_req = 1'b1;
    repeat (50) step();
    check("bp_busy", 32'(busy), 32'd1);
    check("bp_no_start", 32'(got_addr.size()), 32'd0);
    fifo_wr_len = 11'd1792;
    wait_start(2, ok, waited);
    check("bp_start_after_room", 32'(ok), 32'd1);
    check("bp_first_addr", rd_sec_addr, 32'(START));

    // Reset in the middle of a transfer with a word in flight.
    step();
    rd_busy = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      rd_val_en   = 1'b1;
      rd_val_data = 16'($urandom);
      step();
    end
    rst = 1'b1;
    image_read_req = 1'b0;
    step();
    check("midrst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_start", 32'(rd_start_en), 32'd0);
    check("midrst_sec_cnt", 32'(sec_cnt), 32'd0);
    check("midrst_err", 32'(err_flag), 32'd0);
    check("midrst_addr", rd_sec_addr, 32'd0);
    rst         = 1'b0;
    rd_val_en   = 1'b0;
    rd_busy     = 1'b0;
    fifo_wr_len = '0;
    step();

    // Table-driven full images; the first also confirms a restart from sector 20000.
    for (int k = 0; k < 6; k++) begin
      if (abort) break;
      run_image(scen[k]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
